// File: rtl/md_pkg.sv
// md_pkg: shared encodings, state enum and default latencies for md_sched
package md_pkg;
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } e_op_t;
    typedef enum logic [1:0] {
        ENG_MULT  = 2'd0,
        ENG_MULTU = 2'd1,
        ENG_DIV   = 2'd2,
        ENG_DIVU  = 2'd3
    } eng_op_t;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/md_sched.sv
// md_sched: issues mult/div ops to the shared engine, times them, commits HI/LO and stalls HI/LO users
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [2:0]  i_e_op,
    input  logic [31:0] i_e_a,
    input  logic [31:0] i_e_b,
    input  logic        i_d_md_use,
    input  logic        i_flush,
    output logic        o_eng_start,
    output logic [1:0]  o_eng_op,
    output logic [31:0] o_eng_a,
    output logic [31:0] o_eng_b,
    input  logic [31:0] i_eng_hi,
    input  logic [31:0] i_eng_lo,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_busy,
    output logic        o_stall
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [31:0]        r_hi, w_hi_nxt;
    logic [31:0]        r_lo, w_lo_nxt;
    logic               w_is_eng;
    logic               w_is_mult;
    logic               w_idle_ok;

    assign w_is_eng    = i_e_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    assign w_is_mult   = i_e_op inside {OP_MULT, OP_MULTU};
    assign w_idle_ok   = (r_state == ST_IDLE) && !i_flush;
    assign o_eng_start = w_idle_ok && w_is_eng;
    assign o_eng_op    = i_e_op[1:0] - 2'd1;
    assign o_eng_a     = i_e_a;
    assign o_eng_b     = i_e_b;
    assign o_hi        = r_hi;
    assign o_lo        = r_lo;
    assign o_busy      = (r_state == ST_RUN);
    assign o_stall     = i_d_md_use && (o_eng_start || o_busy);

    // next state: start/mthi/mtlo in IDLE; countdown, commit or flush-abort in RUN
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        if (r_state == ST_IDLE) begin
            if (o_eng_start) begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = w_is_mult ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
            end else if (w_idle_ok) begin
                w_hi_nxt = (i_e_op == OP_MTHI) ? i_e_a : r_hi;
                w_lo_nxt = (i_e_op == OP_MTLO) ? i_e_a : r_lo;
            end
        end else if (i_flush) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
            w_hi_nxt    = i_eng_hi;
            w_lo_nxt    = i_eng_lo;
            w_state_nxt = ST_IDLE;
        end
    end

    // state, countdown and architectural HI/LO registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end
endmodule

// File: doc/md_sched.md
# md_sched

Controller that sequences the shared multiply/divide engine (mult_and_div) for the pipelined CPU. It accepts HI/LO-class operations from the E stage and issues a one-cycle start with operands to the engine. It times the operation with an internal countdown, commits the engine result into the architectural HI/LO registers, and raises the D-stage stall for any HI/LO user while the engine is occupied. Exceptions flush in-flight work.

## Interface
- MULT_CYCLES, 5, engine latency for mult/multu, in cycles (≥2)
- DIV_CYCLES, 10, engine latency for div/divu, in cycles (≥2)
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately
- e_op  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- e_a, e_b  in  32  E-stage rs/rt operands
- d_md_use  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- flush  in  1  exception flush of E stage and in-flight operation
- eng_start  out  1  one-cycle start pulse to engine
- eng_op  out  2  0 mult, 1 multu, 2 div, 3 divu
- eng_a, eng_b  out  32  engine operands
- eng_hi, eng_lo  in  32  engine results, valid on the commit cycle
- hi, lo  out  32  architectural HI/LO
- busy  out  1  engine occupied
- stall  out  1  freeze D stage and bubble E

## Operation
- Reset values: state IDLE, cnt 0, hi 0, lo 0, busy 0, eng_start 0, stall 0.
- States: IDLE, RUN.
- eng_start = (state==IDLE) && e_op∈{1..4} && !flush. It is combinational. eng_op, eng_a and eng_b pass e_op-1, e_a and e_b through combinationally.
- IDLE, eng_start: at the edge, cnt ← (mult ? MULT_CYCLES : DIV_CYCLES) − 1 and the state moves to RUN.
- IDLE, e_op 5/6, !flush: at the edge, hi ← e_a (mthi) or lo ← e_a (mtlo).
- RUN, cnt≠0, !flush: cnt ← cnt−1.
- RUN, cnt==0, !flush: hi ← eng_hi, lo ← eng_lo, state → IDLE.
- RUN, flush: state → IDLE, cnt ← 0. hi and lo are unchanged and engine results are discarded.
- busy = (state==RUN). It is registered-state-derived.
- stall = d_md_use && (eng_start || busy).
- Any e_op 1..6 arriving in RUN is a protocol violation. It is ignored: no start, no HI/LO write. A bench assertion flags it.
- flush with an op in IDLE: no start and no HI/LO write.
- cnt width is $clog2(max(MULT_CYCLES, DIV_CYCLES)). There is no wrap, because cnt is never decremented at 0.

## Timing
- Op sampled at edge 0 (eng_start high in the cycle before edge 0). busy is high for exactly N cycles, from after edge 0 to after edge N.
- hi/lo update at edge N and are readable by mfhi/mflo in the cycle after edge N. N is 5 for mult and 10 for div.
- stall is asserted in the start cycle and in all N busy cycles whenever d_md_use=1.
- mthi/mtlo: one-edge latency. Back-to-back mthi then mult in the next cycle is legal.
- Reset asserted mid-RUN: immediate return to reset values. Deassertion is synchronous-safe (external synchronizer).
- A flush on the same edge as commit (cnt==0) takes priority: no commit.

## Structure
- Shared package md_pkg: e_op encodings, eng_op encodings, state enum (IDLE, RUN), default latency constants.
- Single module with no sub-modules. The engine (mult_and_div) is instantiated alongside in the E stage, not inside md_sched.

## Test plan
- mult, e_a=3, e_b=0xFFFFFFFC: eng_start for 1 cycle, busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF4.
- divu, e_a=100, e_b=7: busy for 10 cycles, then hi=2, lo=14. With d_md_use=1 throughout, stall is high for 11 cycles and drops in the cycle busy falls.
- mtlo e_a=0x12345678 in IDLE: lo=0x12345678 after 1 edge, busy stays 0, stall 0.
- div started, flush at busy cycle 4: busy falls after that edge, hi/lo keep their prior values, and a following mult starts normally.
- flush in the same cycle as e_op=mult: eng_start=0, busy never rises.
- reset driven low in busy cycle 2 of a mult: hi=lo=0, busy=0 immediately (no clock needed).
